move_queue_sequencer: RTL and testbench
=======================================

// Module: move_queue_sequencer
// PURPOSE
//   Buffers linear-move commands (per-axis signed step counts and main speeds for X,Y,Z,E0,E1)
//   and issues them one at a time to jerk_acc_speed. Drives num_*_m, speed_*_main and
//   start_driving_main; consumes finish/error. Sits between the command decoder and the
//   motion profile generator. Overlaps command reception with motion execution.
// PARAMETERS
//   DEPTH  8  queue entries; power of two, >=2
//   AW     3  log2(DEPTH); pointer width
// PORTS
//   clk                 in   1    system clock
//   reset               in   1    synchronous, active-low reset
//   cmd_valid           in   1    command present on cmd_steps/cmd_speeds
//   cmd_ready           out  1    queue can accept (not full, not in ERR)
//   cmd_steps           in   160  signed steps {x,y,z,e0,e1}; x = [159:128]
//   cmd_speeds          in   160  unsigned main speeds, same packing
//   hold                in   1    1 = do not launch new moves (running move completes)
//   clear_error         in   1    leave ERR state
//   finish              in   1    from jerk_acc_speed
//   error               in   1    from jerk_acc_speed
//   num_{x,y,z,e0,e1}_m          out  32 signed  step counts of current move
//   speed_{x,y,z,e0,e1}_main     out  32         speeds of current move
//   start_driving_main  out  1    move request to jerk_acc_speed
//   queue_count         out  AW+1 entries stored (excludes the running move)
//   busy                out  1    state != IDLE
//   fault               out  1    state == ERR
//   moves_done          out  16   completed moves, wraps 0xFFFF->0
// BEHAVIOUR
//   Reset (reset==0 at a clk edge): all outputs 0; pointers 0; state IDLE; overrides all inputs.
//   Write: accepted on an edge where cmd_valid && cmd_ready; no bypass path.
//     cmd_ready = (queue_count != DEPTH) && state != ERR.
//     A pop on the same edge as a full-queue write does not make room; the write is refused.
//   FSM: IDLE, RUN, RELEASE, ERR.
//   IDLE: if queue non-empty && !hold: pop head.
//     All-zero head (cmd_steps==0) -> discarded. Stay IDLE. No start, moves_done unchanged.
//     Otherwise -> load num_*/speed_* regs, start_driving_main<=1, ->RUN.
//     Latency: entry written at edge n into empty queue -> start_driving_main high after edge n+1.
//   RUN: hold start=1 and operands stable; on finish==1 -> start<=0, moves_done+1, ->RELEASE.
//   RELEASE: wait finish==0 -> IDLE. Next pop no earlier than the edge after finish falls.
//   Operand regs keep their last values in IDLE/RELEASE; they change only on a launch.
//   ERR entry: error==1 in any non-ERR state (priority over finish on the same edge):
//     start<=0, flush queue (count<=0, rd=wr ptr), moves_done unchanged, fault=1.
//   ERR: queue writes refused. clear_error==1 -> IDLE; error still high re-enters ERR next edge.
//   hold does not affect writes, RUN or RELEASE.
//   Pointers wrap modulo DEPTH. queue_count updates on the same edge as the push/pop.
// TESTING
//   1. Push X=81515,Y=98466,Z=78678, speeds 10000/8333/7500 -> start high 1 cycle after push,
//      operands match; finish pulse -> start low, moves_done=1.
//   2. Push 9 commands while first runs (DEPTH=8) -> 9th refused when count=8, cmd_ready=0;
//      all 8 accepted moves issued in FIFO order.
//   3. Push all-zero-steps entry then X=100 -> zero entry dropped, only X=100 launched,
//      moves_done=1.
//   4. error=1 during RUN with 3 queued -> start=0, queue_count=0, fault=1;
//      clear_error -> IDLE, queue accepts again.
//   5. hold=1, push 2 moves -> no start, count=2; release hold -> first launches next edge.
//   6. reset low mid-RUN with count=5 -> all outputs 0, count=0, IDLE next edge.

Source files
------------

// File: rtl/move_queue_sequencer.sv
// Queues linear-move commands and launches them one at a time to the profile generator.
// Latency: a write into an empty queue launches on the following edge; finish/error act in one edge.
// Backpressure: cmd_ready drops when the queue is full or in ERR; a pop never frees room on the same edge.

module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push_vld,
    input  logic [W-1:0]  push_dat,
    output logic          push_rdy,
    input  logic          pop,
    output logic [W-1:0]  pop_dat,
    output logic [AW:0]   count
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    // Fullness is judged on the pre-edge count, so a simultaneous pop cannot admit a write.
    assign push_rdy = (count != FULL_CNT);
    assign do_push  = push_vld && push_rdy && !flush;
    assign do_pop   = pop && (count != '0) && !flush;
    assign pop_dat  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

module move_queue_sequencer #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [159:0]        cmd_steps,
    input  logic [159:0]        cmd_speeds,
    input  logic                hold,
    input  logic                clear_error,
    input  logic                finish,
    input  logic                error,
    output logic signed [31:0]  num_x_m,
    output logic signed [31:0]  num_y_m,
    output logic signed [31:0]  num_z_m,
    output logic signed [31:0]  num_e0_m,
    output logic signed [31:0]  num_e1_m,
    output logic [31:0]         speed_x_main,
    output logic [31:0]         speed_y_main,
    output logic [31:0]         speed_z_main,
    output logic [31:0]         speed_e0_main,
    output logic [31:0]         speed_e1_main,
    output logic                start_driving_main,
    output logic [AW:0]         queue_count,
    output logic                busy,
    output logic                fault,
    output logic [15:0]         moves_done
);
    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        logic [31:0] e0;
        logic [31:0] e1;
    } axis_t;

    typedef struct packed {
        axis_t steps;
        axis_t speeds;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, RUN, RELEASE, ERR} state_t;

    state_t state, state_nxt;
    cmd_t   push_cmd, head_cmd;
    logic   q_rdy, q_pop, q_flush, launch, move_done;

    assign push_cmd  = '{steps: cmd_steps, speeds: cmd_speeds};
    // Gated by reset so every output reads 0 while reset is held.
    assign cmd_ready = reset && q_rdy && (state != ERR);
    assign busy      = (state != IDLE);
    assign fault     = (state == ERR);

    sync_fifo #(.W($bits(cmd_t)), .DEPTH(DEPTH), .AW(AW)) u_queue (
        .clk      (clk),
        .reset    (reset),
        .flush    (q_flush),
        .push_vld (cmd_valid && cmd_ready),
        .push_dat (push_cmd),
        .push_rdy (q_rdy),
        .pop      (q_pop),
        .pop_dat  (head_cmd),
        .count    (queue_count)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // error outranks finish and pops in every non-ERR state.
    always_comb begin
        state_nxt = state;
        q_pop     = 1'b0;
        q_flush   = 1'b0;
        launch    = 1'b0;
        move_done = 1'b0;
        case (state)
            IDLE: begin
                if (error) begin
                    state_nxt = ERR;
                    q_flush   = 1'b1;
                end else if (queue_count != '0 && !hold) begin
                    q_pop = 1'b1;
                    if (head_cmd.steps != '0) begin
                        launch    = 1'b1;
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (error) begin
                    state_nxt = ERR;
                    q_flush   = 1'b1;
                end else if (finish) begin
                    move_done = 1'b1;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                if (error) begin
                    state_nxt = ERR;
                    q_flush   = 1'b1;
                end else if (!finish) begin
                    state_nxt = IDLE;
                end
            end
            ERR: begin
                if (clear_error) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            start_driving_main <= 1'b0;
            moves_done         <= '0;
            num_x_m            <= '0;
            num_y_m            <= '0;
            num_z_m            <= '0;
            num_e0_m           <= '0;
            num_e1_m           <= '0;
            speed_x_main       <= '0;
            speed_y_main       <= '0;
            speed_z_main       <= '0;
            speed_e0_main      <= '0;
            speed_e1_main      <= '0;
        end else begin
            if (launch) begin
                start_driving_main <= 1'b1;
                num_x_m            <= head_cmd.steps.x;
                num_y_m            <= head_cmd.steps.y;
                num_z_m            <= head_cmd.steps.z;
                num_e0_m           <= head_cmd.steps.e0;
                num_e1_m           <= head_cmd.steps.e1;
                speed_x_main       <= head_cmd.speeds.x;
                speed_y_main       <= head_cmd.speeds.y;
                speed_z_main       <= head_cmd.speeds.z;
                speed_e0_main      <= head_cmd.speeds.e0;
                speed_e1_main      <= head_cmd.speeds.e1;
            end else if (move_done || q_flush) begin
                start_driving_main <= 1'b0;
            end
            if (move_done) moves_done <= moves_done + 1'b1;
        end
    end
endmodule

// File: tb/tb_move_queue_sequencer.sv
// Directed bench for move_queue_sequencer: inputs change and outputs are sampled on the falling edge.
module tb_move_queue_sequencer;
    logic               clk = 1'b0;
    logic               reset, cmd_valid, hold, clear_error, finish, error;
    logic [159:0]       cmd_steps, cmd_speeds;
    logic               cmd_ready, start_driving_main, busy, fault;
    logic signed [31:0] num_x_m, num_y_m, num_z_m, num_e0_m, num_e1_m;
    logic [31:0]        speed_x_main, speed_y_main, speed_z_main, speed_e0_main, speed_e1_main;
    logic [3:0]         queue_count;
    logic [15:0]        moves_done;

    int errors = 0;
    int checks = 0;
    int md     = 0;

    always #5 clk = ~clk;

    move_queue_sequencer dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_steps(cmd_steps), .cmd_speeds(cmd_speeds), .hold(hold),
        .clear_error(clear_error), .finish(finish), .error(error),
        .num_x_m(num_x_m), .num_y_m(num_y_m), .num_z_m(num_z_m),
        .num_e0_m(num_e0_m), .num_e1_m(num_e1_m),
        .speed_x_main(speed_x_main), .speed_y_main(speed_y_main), .speed_z_main(speed_z_main),
        .speed_e0_main(speed_e0_main), .speed_e1_main(speed_e1_main),
        .start_driving_main(start_driving_main), .queue_count(queue_count),
        .busy(busy), .fault(fault), .moves_done(moves_done)
    );

    function automatic logic [159:0] pk(input int a, input int b, input int c, input int d, input int e);
        return {a, b, c, d, e};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push(input logic [159:0] s, input logic [159:0] sp);
        cmd_steps = s; cmd_speeds = sp; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic pulse_finish();
        finish = 1'b1; step();
        finish = 1'b0; step();
        md++;
    endtask

    task automatic test_reset();
        reset = 1'b0; cmd_valid = 0; hold = 0; clear_error = 0; finish = 0; error = 0;
        cmd_steps = '0; cmd_speeds = '0;
        step(); step();
        checks++; if ({start_driving_main, busy, fault, cmd_ready} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got=%b exp=0000", {start_driving_main, busy, fault, cmd_ready}); end
        checks++; if (queue_count !== 4'd0 || moves_done !== 16'd0) begin
            errors++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", queue_count, moves_done); end
        checks++; if (num_x_m !== 32'sd0 || speed_x_main !== 32'd0) begin
            errors++; $display("FAIL reset_operands got=%0d/%0d exp=0/0", num_x_m, speed_x_main); end
        reset = 1'b1; step();
        checks++; if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
    endtask

    task automatic test_single();
        push(pk(81515, 98466, 78678, 0, 0), pk(10000, 8333, 7500, 0, 0));
        checks++; if (queue_count !== 4'd1 || start_driving_main !== 1'b0) begin
            errors++; $display("FAIL single_queued got=%0d/%b exp=1/0", queue_count, start_driving_main); end
        step();
        checks++; if (start_driving_main !== 1'b1 || queue_count !== 4'd0 || busy !== 1'b1) begin
            errors++; $display("FAIL single_launch got=%b/%0d/%b exp=1/0/1", start_driving_main, queue_count, busy); end
        checks++; if (num_x_m !== 81515 || num_y_m !== 98466 || num_z_m !== 78678 || num_e0_m !== 0) begin
            errors++; $display("FAIL single_steps got=%0d,%0d,%0d,%0d exp=81515,98466,78678,0", num_x_m, num_y_m, num_z_m, num_e0_m); end
        checks++; if (speed_x_main !== 10000 || speed_y_main !== 8333 || speed_z_main !== 7500) begin
            errors++; $display("FAIL single_speeds got=%0d,%0d,%0d exp=10000,8333,7500", speed_x_main, speed_y_main, speed_z_main); end
        step(); step();
        checks++; if (start_driving_main !== 1'b1 || num_x_m !== 81515) begin
            errors++; $display("FAIL single_hold_run got=%b/%0d exp=1/81515", start_driving_main, num_x_m); end
        finish = 1'b1; step();
        checks++; if (start_driving_main !== 1'b0 || moves_done !== 16'(md + 1) || busy !== 1'b1) begin
            errors++; $display("FAIL single_finish got=%b/%0d/%b exp=0/%0d/1", start_driving_main, moves_done, busy, md + 1); end
        step();
        checks++; if (busy !== 1'b1 || start_driving_main !== 1'b0) begin
            errors++; $display("FAIL single_release got=%b/%b exp=1/0", busy, start_driving_main); end
        finish = 1'b0; step();
        md++;
        checks++; if (busy !== 1'b0 || num_x_m !== 81515) begin
            errors++; $display("FAIL single_idle got=%b/%0d exp=0/81515", busy, num_x_m); end
    endtask

    task automatic test_full();
        push(pk(1, 0, 0, 0, 0), pk(111, 0, 0, 0, 0));
        step();
        for (int i = 0; i < 9; i++) begin
            cmd_steps = pk(2 + i, 0, 0, 0, 0); cmd_speeds = pk(100 * (2 + i), 0, 0, 0, 0);
            cmd_valid = 1'b1;
            if (i == 8) begin
                checks++; if (cmd_ready !== 1'b0 || queue_count !== 4'd8) begin
                    errors++; $display("FAIL full_refuse got=%b/%0d exp=0/8", cmd_ready, queue_count); end
            end
            step();
        end
        cmd_valid = 1'b0;
        checks++; if (queue_count !== 4'd8) begin
            errors++; $display("FAIL full_count got=%0d exp=8", queue_count); end
        for (int k = 0; k < 9; k++) begin
            checks++; if (start_driving_main !== 1'b1 || num_x_m !== k + 1) begin
                errors++; $display("FAIL full_order%0d got=%b/%0d exp=1/%0d", k, start_driving_main, num_x_m, k + 1); end
            if (k == 4) begin
                checks++; if (speed_x_main !== 500 || queue_count !== 4'd4) begin
                    errors++; $display("FAIL full_mid got=%0d/%0d exp=500/4", speed_x_main, queue_count); end
            end
            pulse_finish();
            step();
        end
        checks++; if (start_driving_main !== 1'b0 || queue_count !== 4'd0 || moves_done !== 16'(md)) begin
            errors++; $display("FAIL full_drained got=%b/%0d/%0d exp=0/0/%0d", start_driving_main, queue_count, moves_done, md); end
    endtask

    task automatic test_zero();
        push(pk(0, 0, 0, 0, 0), pk(5, 5, 5, 5, 5));
        push(pk(100, 0, 0, 0, 0), pk(200, 0, 0, 0, 0));
        checks++; if (start_driving_main !== 1'b0 || queue_count !== 4'd1 || busy !== 1'b0) begin
            errors++; $display("FAIL zero_drop got=%b/%0d/%b exp=0/1/0", start_driving_main, queue_count, busy); end
        step();
        checks++; if (start_driving_main !== 1'b1 || num_x_m !== 100 || moves_done !== 16'(md)) begin
            errors++; $display("FAIL zero_next got=%b/%0d/%0d exp=1/100/%0d", start_driving_main, num_x_m, moves_done, md); end
        pulse_finish();
        checks++; if (moves_done !== 16'(md)) begin
            errors++; $display("FAIL zero_done got=%0d exp=%0d", moves_done, md); end
    endtask

    task automatic test_error();
        push(pk(7, 0, 0, 0, 0), pk(70, 0, 0, 0, 0));
        step();
        for (int i = 8; i < 11; i++) push(pk(i, 0, 0, 0, 0), pk(10 * i, 0, 0, 0, 0));
        checks++; if (queue_count !== 4'd3 || start_driving_main !== 1'b1) begin
            errors++; $display("FAIL err_setup got=%0d/%b exp=3/1", queue_count, start_driving_main); end
        error = 1'b1; finish = 1'b1; step();
        error = 1'b0; finish = 1'b0;
        checks++; if (start_driving_main !== 1'b0 || queue_count !== 4'd0 || fault !== 1'b1) begin
            errors++; $display("FAIL err_enter got=%b/%0d/%b exp=0/0/1", start_driving_main, queue_count, fault); end
        checks++; if (moves_done !== 16'(md) || cmd_ready !== 1'b0 || num_x_m !== 7) begin
            errors++; $display("FAIL err_state got=%0d/%b/%0d exp=%0d/0/7", moves_done, cmd_ready, num_x_m, md); end
        push(pk(50, 0, 0, 0, 0), pk(1, 0, 0, 0, 0));
        checks++; if (queue_count !== 4'd0 || fault !== 1'b1) begin
            errors++; $display("FAIL err_refuse got=%0d/%b exp=0/1", queue_count, fault); end
        clear_error = 1'b1; step();
        clear_error = 1'b0;
        checks++; if (fault !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL err_clear got=%b/%b/%b exp=0/0/1", fault, busy, cmd_ready); end
        push(pk(11, 0, 0, 0, 0), pk(110, 0, 0, 0, 0));
        step();
        checks++; if (start_driving_main !== 1'b1 || num_x_m !== 11) begin
            errors++; $display("FAIL err_resume got=%b/%0d exp=1/11", start_driving_main, num_x_m); end
        pulse_finish();
    endtask

    task automatic test_hold();
        hold = 1'b1;
        push(pk(20, 0, 0, 0, 0), pk(1, 0, 0, 0, 0));
        push(pk(21, -3, 0, 0, 0), pk(2, 0, 0, 0, 0));
        step();
        checks++; if (start_driving_main !== 1'b0 || queue_count !== 4'd2 || busy !== 1'b0) begin
            errors++; $display("FAIL hold_block got=%b/%0d/%b exp=0/2/0", start_driving_main, queue_count, busy); end
        hold = 1'b0; step();
        checks++; if (start_driving_main !== 1'b1 || num_x_m !== 20 || queue_count !== 4'd1) begin
            errors++; $display("FAIL hold_release got=%b/%0d/%0d exp=1/20/1", start_driving_main, num_x_m, queue_count); end
        pulse_finish();
        step();
        checks++; if (num_x_m !== 21 || num_y_m !== -3 || start_driving_main !== 1'b1) begin
            errors++; $display("FAIL hold_second got=%0d/%0d/%b exp=21/-3/1", num_x_m, num_y_m, start_driving_main); end
        pulse_finish();
    endtask

    task automatic test_reset_mid();
        push(pk(30, 0, 0, 0, 0), pk(300, 0, 0, 0, 0));
        step();
        for (int i = 31; i < 36; i++) push(pk(i, 0, 0, 0, 0), pk(1, 0, 0, 0, 0));
        checks++; if (queue_count !== 4'd5 || start_driving_main !== 1'b1) begin
            errors++; $display("FAIL rst_setup got=%0d/%b exp=5/1", queue_count, start_driving_main); end
        reset = 1'b0; step();
        md = 0;
        checks++; if ({start_driving_main, busy, fault} !== 3'b000 || queue_count !== 4'd0 || moves_done !== 16'd0) begin
            errors++; $display("FAIL rst_mid got=%b/%0d/%0d exp=000/0/0", {start_driving_main, busy, fault}, queue_count, moves_done); end
        checks++; if (num_x_m !== 0 || speed_x_main !== 0) begin
            errors++; $display("FAIL rst_operands got=%0d/%0d exp=0/0", num_x_m, speed_x_main); end
        reset = 1'b1; step();
        checks++; if (cmd_ready !== 1'b1 || start_driving_main !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_after got=%b/%b/%b exp=1/0/0", cmd_ready, start_driving_main, busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_zero();
        test_error();
        test_hold();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
